// File: rtl/mux_stream_n1_if.sv
// Handshake and select bundle for the N-to-1 streaming multiplexer.
// The slave modport is the multiplexer side; master is whoever drives the channels and sinks the output.
interface mux_stream_n1_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);
    localparam int SEL_W = (CH > 2) ? $clog2(CH) : 1;

    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic [SEL_W-1:0]    sel_req;
    logic                sel_load;
    logic [SEL_W-1:0]    sel_cur;
    logic                busy;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, sel_req, sel_load, out_ready,
        input  in_ready, sel_cur, busy, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel_req, sel_load, out_ready,
        output in_ready, sel_cur, busy, out_data, out_valid
    );
endinterface

// File: rtl/mux_stream_n1.sv
// N-to-1 streaming multiplexer with a registered output word and a drain-then-guard
// channel switch, so a switch never duplicates, drops or mixes words across channels.
module mux_stream_n1 #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int GUARD = 2
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    mux_stream_n1_if.slave bus
);
    localparam int SEL_W = (CH > 2) ? $clog2(CH) : 1;
    localparam int CNT_W = (GUARD > 2) ? $clog2(GUARD) : 1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GUARD} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_cur;
    logic [SEL_W-1:0] pending;
    logic             busy;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CNT_W-1:0] guard_cnt;

    logic [CH-1:0]    in_ready;
    logic             take;
    logic             drained;
    logic             req_ok;

    // Only the connected channel may be ready, and only while no switch is running.
    always_comb begin
        in_ready = '0;
        if (sys_rst_n && state == ST_RUN) begin
            in_ready[sel_cur] = ~out_valid | bus.out_ready;
        end
    end

    assign take    = bus.in_valid[sel_cur] & in_ready[sel_cur];
    assign drained = ~out_valid | bus.out_ready;
    assign req_ok  = bus.sel_load && (32'(bus.sel_req) < CH) && (bus.sel_req != sel_cur);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_RUN;
            sel_cur   <= '0;
            pending   <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            guard_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take) begin
                        out_data  <= bus.in_data[sel_cur*WIDTH +: WIDTH];
                        out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                    // A word accepted in the request cycle still completes; DRAIN flushes it.
                    if (req_ok) begin
                        pending <= bus.sel_req;
                        busy    <= 1'b1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        out_valid <= 1'b0;
                        if (GUARD > 0) begin
                            state     <= ST_GUARD;
                            guard_cnt <= '0;
                        end else begin
                            sel_cur <= pending;
                            busy    <= 1'b0;
                            state   <= ST_RUN;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        sel_cur   <= pending;
                        busy      <= 1'b0;
                        guard_cnt <= '0;
                        state     <= ST_RUN;
                    end else begin
                        guard_cnt <= guard_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sel_cur   = sel_cur;
    assign bus.busy      = busy;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
endmodule

// File: doc/mux_stream_n1.md
# mux_stream_n1

Parametrised N-to-1 streaming multiplexer with registered output, valid/ready handshake per channel, and a controlled channel-switch sequence. Replaces the single-bit 2:1 combinational mux for multi-bit, multi-channel data paths: selection changes only at word boundaries, after the output register drains and a programmable guard interval elapses. No word is duplicated, dropped or mixed across channels during a switch.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CH, 4, number of input channels (≥2)
- GUARD, 2, idle cycles inserted between drain completion and new channel becoming active (0 allowed)
- SEL_W, derived = max(1, clog2(CH)), select width; not overridable
- sys_clk  input  1  rising-edge clock, single domain
- sys_rst_n  input  1  asynchronous, active-low reset
- in_data  input  CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CH  per-channel valid
- in_ready  output  CH  per-channel ready
- sel_req  input  SEL_W  requested channel
- sel_load  input  1  one-cycle strobe: request switch to sel_req
- sel_cur  output  SEL_W  currently connected channel (registered)
- busy  output  1  high while a switch is in progress (registered)
- out_data  output  WIDTH  registered output word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream ready

## Operation
- States: RUN, DRAIN, GUARD. Reset state RUN.
- RUN: in_ready[sel_cur] = ~out_valid | out_ready; all other in_ready bits 0. On in_valid[sel_cur] & in_ready[sel_cur]: out_data <= channel sel_cur word, out_valid <= 1. On out_valid & out_ready with no new transfer: out_valid <= 0.
- Switch request: sel_load in RUN with sel_req < CH and sel_req ≠ sel_cur → latch sel_req into pending, busy <= 1, go DRAIN. Same cycle's input transfer (if handshake true) still completes.
- sel_load with sel_req == sel_cur, sel_req ≥ CH, or while busy: ignored, no state change.
- DRAIN: all in_ready = 0. Leave when out_valid == 0, or out_valid & out_ready this cycle. Exit to GUARD if GUARD > 0, else directly to RUN with sel_cur <= pending, busy <= 0.
- GUARD: all in_ready = 0, out_valid = 0; count GUARD cycles, then sel_cur <= pending, busy <= 0, RUN.
- out_data holds its last value when out_valid = 0.
- Reset mid-switch: pending discarded, sel_cur returns to 0.

## Timing
- Reset values: out_data 0, out_valid 0, sel_cur 0, busy 0, state RUN, guard counter 0; in_ready all 0 while sys_rst_n low.
- Latency: accepted input appears on out_data/out_valid the next cycle. Full throughput of 1 word/cycle with out_ready held high.
- in_ready is combinational from state, sel_cur, out_valid, out_ready; no combinational path from in_valid or in_data to in_ready.
- Switch cost with empty output register and out_ready = 1: sel_load at cycle t → busy at t+1, DRAIN exits at t+1, GUARD cycles t+2..t+1+GUARD, sel_cur updated and new channel ready at t+2+GUARD (t+2 when GUARD = 0).
- DRAIN stalls indefinitely while out_ready = 0; busy remains 1.
- Backpressure: out_data/out_valid stable while out_valid & ~out_ready.

## Test plan
- Reset: hold sys_rst_n low with all in_valid = 1 → all in_ready 0, out_valid 0, sel_cur 0; release → in_ready = 4'b0001 next cycle.
- Streaming: ch0 sends 0x10..0x1F back-to-back, out_ready = 1 → 16 words on out_data in order, 1-cycle latency, no gaps; other channels' in_ready stay 0.
- Backpressure: out_ready low for 5 cycles mid-stream → out_data frozen, in_ready[0] = 0, no loss or duplication after release.
- Switch with GUARD = 2: sel_load with sel_req = 3 while out_valid = 1 and out_ready = 0 → busy holds until word accepted, then 2 idle cycles, sel_cur = 3, first ch3 word follows; no ch0 word after the switch.
- Ignored requests: sel_load with sel_req = sel_cur, sel_req = 5 with CH = 5 → no busy; sel_load during busy → original pending channel wins.
- Reset mid-GUARD: assert sys_rst_n low → immediate return to reset values, sel_cur = 0, pending channel not applied.
